// File: rtl/simple_npu_pkg.sv
// Shared widths and helpers for the simple_npu systolic matrix-multiply tile.
package simple_npu_pkg;

    localparam int DATA_W = 8;
    localparam int PROD_W = 16;

    // Accumulator width for an N-term dot product of 8x8 unsigned products.
    function automatic int acc_width(input int n);
        return PROD_W + n - 1;
    endfunction

endpackage

// File: rtl/npu_pe.sv
// Output-stationary processing element: multiply-accumulate plus operand pass-through.
module npu_pe
    import simple_npu_pkg::*;
#(
    parameter int ACC_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] a_out,
    output logic [DATA_W-1:0] b_out,
    output logic [ACC_W-1:0]  acc
);

    // Widen before multiplying so the full 16-bit product is kept.
    logic [PROD_W-1:0] prod;
    assign prod = PROD_W'(a_in) * PROD_W'(b_in);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/simple_npu.sv
// N x N output-stationary systolic array computing C = A x B once per reset release.
module simple_npu
    import simple_npu_pkg::*;
#(
    parameter int N = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        A   [N][N],
    input  logic [DATA_W-1:0]        B   [N][N],
    output logic [acc_width(N)-1:0]  out [N*N]
);

    localparam int ACC_W   = acc_width(N);
    localparam int CNT_MAX = 3 * N - 2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] a_feed [N];
    logic [DATA_W-1:0] b_feed [N];
    logic [DATA_W-1:0] a_pass [N][N];
    logic [DATA_W-1:0] b_pass [N][N];

    // Saturating step counter; the skewed feeds are all zero once it tops out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (cnt != CNT_W'(CNT_MAX)) begin
            cnt <= cnt + 1'b1;
        end
    end

    genvar gi, gj;
    generate
        for (gi = 0; gi < N; gi++) begin : g_feed
            // Row gi of A (and column gi of B) enters delayed by gi steps.
            always_comb begin
                a_feed[gi] = '0;
                b_feed[gi] = '0;
                for (int k = 0; k < N; k++) begin
                    if (cnt == CNT_W'(gi + k)) begin
                        a_feed[gi] = A[gi][k];
                        b_feed[gi] = B[k][gi];
                    end
                end
            end
        end

        for (gi = 0; gi < N; gi++) begin : g_row
            for (gj = 0; gj < N; gj++) begin : g_col
                logic [DATA_W-1:0] a_src;
                logic [DATA_W-1:0] b_src;

                if (gj == 0) begin : g_a_edge
                    assign a_src = a_feed[gi];
                end else begin : g_a_int
                    assign a_src = a_pass[gi][gj-1];
                end

                if (gi == 0) begin : g_b_edge
                    assign b_src = b_feed[gj];
                end else begin : g_b_int
                    assign b_src = b_pass[gi-1][gj];
                end

                npu_pe #(
                    .ACC_W (ACC_W)
                ) u_pe (
                    .clk   (clk),
                    .rst   (rst),
                    .a_in  (a_src),
                    .b_in  (b_src),
                    .a_out (a_pass[gi][gj]),
                    .b_out (b_pass[gi][gj]),
                    .acc   (out[gi*N+gj])
                );
            end
        end
    endgenerate

endmodule

// File: tb/tb_simple_npu.sv
// Self-checking bench for simple_npu at N=2 and N=3 against a matrix-product model.
module tb_simple_npu;

    logic       clk = 1'b0;
    logic       rst2 = 1'b0;
    logic       rst3 = 1'b0;
    logic [7:0] A2 [2][2];
    logic [7:0] B2 [2][2];
    logic [7:0] A3 [3][3];
    logic [7:0] B3 [3][3];
    logic [16:0] out2 [4];
    logic [17:0] out3 [9];

    int ma [3][3];
    int mb [3][3];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    simple_npu #(.N(2)) dut2 (.clk(clk), .rst(rst2), .A(A2), .B(B2), .out(out2));
    simple_npu #(.N(3)) dut3 (.clk(clk), .rst(rst3), .A(A3), .B(B3), .out(out3));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Partial dot product after e edges: term k lands on edge i+j+k+1.
    function automatic int model(input int n, input int i, input int j, input int e);
        int s = 0;
        for (int k = 0; k < n; k++)
            if (i + j + k < e) s += ma[i][k] * mb[k][j];
        return s;
    endfunction

    function automatic logic [31:0] get_out(input int n, input int idx);
        if (n == 2) return 32'(out2[idx]);
        return 32'(out3[idx]);
    endfunction

    task automatic set_rst(input int n, input logic v);
        if (n == 2) rst2 = v;
        else rst3 = v;
    endtask

    task automatic drive(input int n);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                if (n == 2) begin
                    A2[i][j] = 8'(ma[i][j]);
                    B2[i][j] = 8'(mb[i][j]);
                end else begin
                    A3[i][j] = 8'(ma[i][j]);
                    B3[i][j] = 8'(mb[i][j]);
                end
            end
    endtask

    task automatic check_all(input int n, input int e, input string tag);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                check($sformatf("%s n=%0d e=%0d out[%0d]", tag, n, e, i*n+j),
                      get_out(n, i*n+j), 32'(model(n, i, j, e)));
    endtask

    // Reset, release at a negedge, then check every output after each edge.
    task automatic run(input int n, input int edges, input string tag);
        drive(n);
        @(negedge clk);
        set_rst(n, 1'b0);
        #1;
        check_all(n, 0, {tag, "_rst"});
        @(negedge clk);
        set_rst(n, 1'b1);
        for (int e = 1; e <= edges; e++) begin
            @(negedge clk);
            check_all(n, e, tag);
        end
        $display("txn %s n=%0d done checks=%0d errors=%0d", tag, n, checks, errors);
    endtask

    task automatic rand_mats(input int n);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = (i < n && j < n) ? int'($urandom_range(0, 255)) : 0;
                mb[i][j] = (i < n && j < n) ? int'($urandom_range(0, 255)) : 0;
            end
    endtask

    initial begin
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = 0;
                mb[i][j] = 0;
            end
        drive(2);
        drive(3);

        // Directed: 19 22 43 50, with visible partial sums.
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        run(2, 8, "basic");
        check("basic_c0", get_out(2, 0), 32'd19);
        check("basic_c3", get_out(2, 3), 32'd50);

        // Maximum operands: no overflow in the 17-bit accumulators.
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ma[i][j] = 255;
                mb[i][j] = 255;
            end
        run(2, 6, "max");
        check("max_c1", get_out(2, 1), 32'd130050);

        // Identity times B.
        ma[0][0] = 1; ma[0][1] = 0; ma[1][0] = 0; ma[1][1] = 1;
        mb[0][0] = 9; mb[0][1] = 8; mb[1][0] = 7; mb[1][1] = 6;
        run(2, 6, "ident");

        // Abort mid-computation with an asynchronous reset between edges.
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        run(2, 2, "pre_abort");
        #2;
        rst2 = 1'b0;
        #1;
        for (int k = 0; k < 4; k++)
            check($sformatf("abort out[%0d]", k), get_out(2, k), 32'd0);
        ma[0][0] = 0; ma[0][1] = 1; ma[1][0] = 1; ma[1][1] = 0;
        run(2, 6, "swap");
        check("swap_c0", get_out(2, 0), 32'd7);
        check("swap_c2", get_out(2, 2), 32'd5);

        for (int t = 0; t < 4; t++) begin
            rand_mats(2);
            run(2, 6, $sformatf("rand2_%0d", t));
        end

        // N=3: A times identity gives A back.
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                ma[i][j] = i * 3 + j + 1;
                mb[i][j] = (i == j) ? 1 : 0;
            end
        run(3, 9, "ident3");
        check("ident3_c8", get_out(3, 8), 32'd9);

        for (int t = 0; t < 3; t++) begin
            rand_mats(3);
            run(3, 9, $sformatf("rand3_%0d", t));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
